datapath_ctrl_fsm: RTL

- Multi-cycle control unit that drives the datapath's control inputs: load, ALUsrc, RegDst, MemtoReg, MemWrite, MemRead, op.
- Until now these inputs came from the bench or switches. This block decodes the fetched 16-bit instruction and sequences them instead.
- It also produces the PC advance strobe and a retired-instruction counter.
- It sits between instruction memory and the datapath top.

---
 rtl/datapath_ctrl_fsm.sv | 137 +++++++++++++
 1 files changed

// File: rtl/datapath_ctrl_fsm.sv
// Multi-cycle control unit: decodes the latched instruction and
// sequences datapath strobes, PC advance and the retired counter.
module datapath_ctrl_fsm #(
  parameter logic [3:0] HALT_OPC = 4'hF,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic [15:0]      instr,
  output logic             pc_en,
  output logic             load,
  output logic             ALUsrc,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             MemRead,
  output logic [2:0]       op,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] opc;
  logic       is_halt, is_r, is_addi;
  logic       is_lw, is_sw, is_def;

  assign opc     = ir_q[15:12];
  assign is_halt = (opc == HALT_OPC);
  assign is_r    = ~opc[3];
  assign is_addi = (opc == 4'h8);
  assign is_lw   = (opc == 4'h9);
  assign is_sw   = (opc == 4'hA);
  assign is_def  = is_r | is_addi | is_lw | is_sw;

  // Next state and Moore outputs from state plus the latched IR
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    pc_en     = 1'b0;
    load      = 1'b0;
    ALUsrc    = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    op        = 3'b000;
    halted    = 1'b0;
    if (state_q == S_EXEC ||
        state_q == S_MEM  ||
        state_q == S_WB) begin
      op       = is_r ? ir_q[14:12] : 3'b000;
      ALUsrc   = ~is_r;
      RegDst   = is_r;
      MemtoReg = is_lw;
    end
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_def) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          pc_en     = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        state_d = (is_lw | is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (is_sw) begin
          MemWrite = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_FETCH;
        end else begin
          MemRead = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        load    = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_W'(pc_en);
  end

  // State, IR, sticky illegal flag and retired counter
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule
